// File: rtl/ara_inval_queue_pkg.sv
// ara_inval_queue_pkg: shared constants and helpers for the Ara -> CVA6 invalidation queue.
//   - Default parameter values for the queue.
//   - line_offset_bits(): number of byte-offset bits inside one L1 D-cache line.
package ara_inval_queue_pkg;

  localparam int unsigned DefaultDepth       = 4;
  localparam int unsigned DefaultAddrWidth   = 64;
  localparam int unsigned DefaultL1LineWidth = 16;
  localparam int unsigned DefaultCntWidth    = 16;

  // A one-byte line has no offset bits; otherwise log2 of the line size.
  function automatic int unsigned line_offset_bits(input int unsigned line_bytes);
    return (line_bytes > 1) ? $clog2(line_bytes) : 0;
  endfunction

endpackage

// File: rtl/ara_inval_match.sv
// ara_inval_match: line-address CAM over the invalidation queue entries.
//   entries_i   : stored line addresses, one per slot
//   valid_i     : per-slot valid mask
//   head_i      : slot index of the current head
//   head_pop_i  : head is being popped this cycle
//   addr_i      : incoming line-aligned address
//   hit_o       : addr_i matches a valid slot, excluding a head popped this cycle
module ara_inval_match #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 64,
  localparam int unsigned PtrWidth = $clog2(Depth)
) (
  input  logic [Depth-1:0][AddrWidth-1:0] entries_i,
  input  logic [Depth-1:0]                valid_i,
  input  logic [PtrWidth-1:0]             head_i,
  input  logic                            head_pop_i,
  input  logic [AddrWidth-1:0]            addr_i,
  output logic                            hit_o
);

  logic [Depth-1:0] w_slot_hit;

  always_comb begin
    w_slot_hit = '0;
    for (int i = 0; i < Depth; i++) begin
      // A head leaving this cycle must not absorb a new request for the same
      // line, or a write landing after the pop would go un-invalidated.
      w_slot_hit[i] = valid_i[i] && (entries_i[i] == addr_i) &&
                      !(head_pop_i && (head_i == PtrWidth'(i)));
    end
  end

  assign hit_o = |w_slot_hit;

endmodule

// File: rtl/ara_inval_queue.sv
// ara_inval_queue: decoupling/coalescing FIFO between Ara's AXI invalidation
// filter and CVA6's L1 D-cache invalidation port.
//   clk_i, rst_ni              : clock, async active-low reset
//   en_i                       : coherence enable; when low, requests are accepted and discarded
//   inval_addr_i/valid_i/ready_o : request side from the filter (ready = !full)
//   inval_addr_o/valid_o/ready_i : line-aligned invalidation to the core
//   empty_o, pending_o         : occupancy status
//   coalesced_o                : saturating count of dropped duplicate requests
module ara_inval_queue
  import ara_inval_queue_pkg::*;
#(
  parameter int unsigned Depth       = DefaultDepth,
  parameter int unsigned AddrWidth   = DefaultAddrWidth,
  parameter int unsigned L1LineWidth = DefaultL1LineWidth,
  parameter int unsigned CntWidth    = DefaultCntWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [AddrWidth-1:0]     inval_addr_i,
  input  logic                     inval_valid_i,
  output logic                     inval_ready_o,
  output logic [AddrWidth-1:0]     inval_addr_o,
  output logic                     inval_valid_o,
  input  logic                     inval_ready_i,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   pending_o,
  output logic [CntWidth-1:0]      coalesced_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned LineOffset = line_offset_bits(L1LineWidth);
  localparam logic [AddrWidth-1:0] LineMask = {AddrWidth{1'b1}} << LineOffset;

  logic [Depth-1:0][AddrWidth-1:0] r_mem;
  logic [Depth-1:0]                r_valid;
  logic [PtrWidth-1:0]             r_wptr;
  logic [PtrWidth-1:0]             r_rptr;
  logic [PtrWidth:0]               r_count;
  logic [CntWidth-1:0]             r_coalesced;

  logic                 w_full;
  logic                 w_empty;
  logic [AddrWidth-1:0] w_line;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_hit;
  logic                 w_push;
  logic                 w_drop;

  assign w_full   = (r_count == (PtrWidth + 1)'(Depth));
  assign w_empty  = (r_count == '0);
  assign w_line   = inval_addr_i & LineMask;
  assign w_accept = inval_valid_i && !w_full;
  assign w_pop    = !w_empty && inval_ready_i;
  // With coherence disabled the request is still consumed so the filter never stalls.
  assign w_push   = w_accept && en_i && !w_hit;
  assign w_drop   = w_accept && en_i && w_hit;

  ara_inval_match #(
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_match (
    .entries_i  (r_mem),
    .valid_i    (r_valid),
    .head_i     (r_rptr),
    .head_pop_i (w_pop),
    .addr_i     (w_line),
    .hit_o      (w_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem       <= '0;
      r_valid     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_coalesced <= '0;
    end else begin
      // Push never targets the popped slot: ready is low whenever wptr == rptr with entries.
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PtrWidth'(1);
      end
      if (w_push) begin
        r_mem[r_wptr]   <= w_line;
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + PtrWidth'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PtrWidth + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PtrWidth + 1)'(1);
      end
      if (w_drop && (r_coalesced != '1)) begin
        r_coalesced <= r_coalesced + CntWidth'(1);
      end
    end
  end

  assign inval_ready_o = !w_full;
  assign inval_valid_o = !w_empty;
  assign inval_addr_o  = r_mem[r_rptr];
  assign empty_o       = w_empty;
  assign pending_o     = r_count;
  assign coalesced_o   = r_coalesced;

endmodule

// File: tb/tb_ara_inval_queue.sv
// tb_ara_inval_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the invalidation queue.
module tb_ara_inval_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned LW    = 16;
  localparam int unsigned CW    = 8;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] addr_in;
  logic          vld_in;
  logic          rdy_out;
  logic [AW-1:0] addr_out;
  logic          vld_out;
  logic          rdy_in;
  logic          empty;
  logic [2:0]    pending;
  logic [CW-1:0] coal;

  int total;
  int bad;

  // Reference model: FIFO of line addresses and a saturating drop counter.
  logic [AW-1:0] mq[$];
  int unsigned   mcoal;

  ara_inval_queue #(
    .Depth       (DEPTH),
    .AddrWidth   (AW),
    .L1LineWidth (LW),
    .CntWidth    (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .inval_addr_i  (addr_in),
    .inval_valid_i (vld_in),
    .inval_ready_o (rdy_out),
    .inval_addr_o  (addr_out),
    .inval_valid_o (vld_out),
    .inval_ready_i (rdy_in),
    .empty_o       (empty),
    .pending_o     (pending),
    .coalesced_o   (coal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Advance one clock with the currently driven inputs, updating the model
  // from the queue rules, then settle 1 time unit after the edge.
  task automatic cycle();
    logic [AW-1:0] line;
    bit full, pop, acc, hit;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy_in;
    acc  = vld_in && !full;
    hit  = 1'b0;
    line = addr_in & ~64'(LW - 1);
    if (acc && en) begin
      foreach (mq[i]) begin
        if (!(pop && i == 0) && mq[i] == line) hit = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc && en) begin
      if (hit) begin
        if (mcoal < CMAX) mcoal++;
      end else begin
        mq.push_back(line);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    en      = 1'b1;
    addr_in = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mcoal = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (vld_out !== 1'b0) begin $display("FAIL reset_valid got=%0b exp=0", vld_out); bad++; end
    total++; if (addr_out !== '0) begin $display("FAIL reset_addr got=%h exp=0", addr_out); bad++; end
    total++; if (rdy_out !== 1'b1) begin $display("FAIL reset_ready got=%0b exp=1", rdy_out); bad++; end
    total++; if (empty !== 1'b1) begin $display("FAIL reset_empty got=%0b exp=1", empty); bad++; end
    total++; if (pending !== 3'd0) begin $display("FAIL reset_pending got=%0d exp=0", pending); bad++; end
    total++; if (coal !== '0) begin $display("FAIL reset_coal got=%0d exp=0", coal); bad++; end
  endtask

  task automatic test_single();
    do_reset();
    rdy_in = 1'b1; vld_in = 1'b1; addr_in = 64'h8000_1234;
    total++; if (vld_out !== 1'b0) begin $display("FAIL single_no_bypass got=%0b exp=0", vld_out); bad++; end
    cycle();
    vld_in = 1'b0;
    total++; if (vld_out !== 1'b1) begin $display("FAIL single_valid got=%0b exp=1", vld_out); bad++; end
    total++; if (addr_out !== 64'h8000_1230) begin $display("FAIL single_addr got=%h exp=80001230", addr_out); bad++; end
    total++; if (pending !== 3'd1) begin $display("FAIL single_pending got=%0d exp=1", pending); bad++; end
    cycle();
    total++; if (vld_out !== 1'b0) begin $display("FAIL single_drained got=%0b exp=0", vld_out); bad++; end
    total++; if (pending !== 3'd0) begin $display("FAIL single_pending0 got=%0d exp=0", pending); bad++; end
    total++; if (coal !== '0) begin $display("FAIL single_coal got=%0d exp=0", coal); bad++; end
  endtask

  task automatic test_coalesce();
    logic [AW-1:0] pushes [4] = '{64'h100, 64'h108, 64'h10F, 64'h110};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1; addr_in = pushes[i];
      total++; if (rdy_out !== 1'b1) begin $display("FAIL coal_ready[%0d] got=%0b exp=1", i, rdy_out); bad++; end
      cycle();
    end
    vld_in = 1'b0;
    total++; if (pending !== 3'd2) begin $display("FAIL coal_pending got=%0d exp=2", pending); bad++; end
    total++; if (coal !== 8'd2) begin $display("FAIL coal_count got=%0d exp=2", coal); bad++; end
    rdy_in = 1'b1;
    total++; if (addr_out !== 64'h100) begin $display("FAIL coal_first got=%h exp=100", addr_out); bad++; end
    cycle();
    total++; if (addr_out !== 64'h110 || vld_out !== 1'b1) begin
      $display("FAIL coal_second got=%h/%0b exp=110/1", addr_out, vld_out); bad++; end
    cycle();
    total++; if (empty !== 1'b1) begin $display("FAIL coal_empty got=%0b exp=1", empty); bad++; end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1; addr_in = 64'h1000 + 64'(16 * i);
      total++; if (rdy_out !== 1'b1) begin $display("FAIL full_ready[%0d] got=%0b exp=1", i, rdy_out); bad++; end
      cycle();
    end
    addr_in = 64'h1040;
    total++; if (rdy_out !== 1'b0) begin $display("FAIL full_not_ready got=%0b exp=0", rdy_out); bad++; end
    total++; if (pending !== 3'd4) begin $display("FAIL full_pending got=%0d exp=4", pending); bad++; end
    total++; if (addr_out !== 64'h1000) begin $display("FAIL full_head got=%h exp=1000", addr_out); bad++; end
    rdy_in = 1'b1;
    cycle();
    rdy_in = 1'b0;
    total++; if (rdy_out !== 1'b1) begin $display("FAIL full_ready_after_pop got=%0b exp=1", rdy_out); bad++; end
    total++; if (pending !== 3'd3) begin $display("FAIL full_pending3 got=%0d exp=3", pending); bad++; end
    cycle();
    vld_in = 1'b0;
    total++; if (pending !== 3'd4) begin $display("FAIL full_fifth got=%0d exp=4", pending); bad++; end
    rdy_in = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++; if (addr_out !== 64'h1000 + 64'(16 * i)) begin
        $display("FAIL full_order[%0d] got=%h exp=%h", i, addr_out, 64'h1000 + 64'(16 * i)); bad++; end
      cycle();
    end
    total++; if (empty !== 1'b1) begin $display("FAIL full_empty got=%0b exp=1", empty); bad++; end
  endtask

  task automatic test_head_pop();
    do_reset();
    vld_in = 1'b1; addr_in = 64'h200;
    cycle();
    rdy_in = 1'b1;
    total++; if (addr_out !== 64'h200) begin $display("FAIL hp_head got=%h exp=200", addr_out); bad++; end
    cycle();
    vld_in = 1'b0; rdy_in = 1'b0;
    total++; if (vld_out !== 1'b1 || addr_out !== 64'h200) begin
      $display("FAIL hp_repush got=%h/%0b exp=200/1", addr_out, vld_out); bad++; end
    total++; if (pending !== 3'd1) begin $display("FAIL hp_pending got=%0d exp=1", pending); bad++; end
    total++; if (coal !== '0) begin $display("FAIL hp_coal got=%0d exp=0", coal); bad++; end
    // A match against a non-head entry while the head pops still coalesces.
    vld_in = 1'b1; addr_in = 64'h300;
    cycle();
    rdy_in = 1'b1;
    cycle();
    vld_in = 1'b0; rdy_in = 1'b0;
    total++; if (addr_out !== 64'h300 || pending !== 3'd1) begin
      $display("FAIL hp_nonhead got=%h/%0d exp=300/1", addr_out, pending); bad++; end
    total++; if (coal !== 8'd1) begin $display("FAIL hp_nonhead_coal got=%0d exp=1", coal); bad++; end
  endtask

  task automatic test_disable();
    do_reset();
    vld_in = 1'b1; addr_in = 64'h400; cycle();
    addr_in = 64'h410; cycle();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_in = (i == 3) ? 64'h404 : 64'h500 + 64'(16 * i);
      total++; if (rdy_out !== 1'b1) begin $display("FAIL dis_ready[%0d] got=%0b exp=1", i, rdy_out); bad++; end
      cycle();
    end
    vld_in = 1'b0;
    total++; if (pending !== 3'd2) begin $display("FAIL dis_pending got=%0d exp=2", pending); bad++; end
    total++; if (coal !== '0) begin $display("FAIL dis_coal got=%0d exp=0", coal); bad++; end
    rdy_in = 1'b1;
    total++; if (addr_out !== 64'h400) begin $display("FAIL dis_drain0 got=%h exp=400", addr_out); bad++; end
    cycle();
    total++; if (addr_out !== 64'h410) begin $display("FAIL dis_drain1 got=%h exp=410", addr_out); bad++; end
    cycle();
    total++; if (empty !== 1'b1) begin $display("FAIL dis_empty got=%0b exp=1", empty); bad++; end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] pushes [4] = '{64'h700, 64'h710, 64'h704, 64'h720};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vld_in = 1'b1; addr_in = pushes[i]; cycle();
    end
    vld_in = 1'b0;
    total++; if (pending !== 3'd3 || vld_out !== 1'b1 || coal !== 8'd1) begin
      $display("FAIL ar_pre got=%0d/%0b/%0d exp=3/1/1", pending, vld_out, coal); bad++; end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (vld_out !== 1'b0) begin $display("FAIL ar_valid got=%0b exp=0", vld_out); bad++; end
    total++; if (pending !== 3'd0) begin $display("FAIL ar_pending got=%0d exp=0", pending); bad++; end
    total++; if (coal !== '0) begin $display("FAIL ar_coal got=%0d exp=0", coal); bad++; end
    total++; if (rdy_out !== 1'b1 || empty !== 1'b1 || addr_out !== '0) begin
      $display("FAIL ar_misc got=%0b/%0b/%h exp=1/1/0", rdy_out, empty, addr_out); bad++; end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mcoal = 0;
    rdy_in = 1'b1; vld_in = 1'b1; addr_in = 64'h8000_1234;
    cycle();
    vld_in = 1'b0;
    total++; if (vld_out !== 1'b1 || addr_out !== 64'h8000_1230) begin
      $display("FAIL ar_fresh got=%h/%0b exp=80001230/1", addr_out, vld_out); bad++; end
    cycle();
    total++; if (pending !== 3'd0) begin $display("FAIL ar_fresh_pending got=%0d exp=0", pending); bad++; end
  endtask

  task automatic test_saturate();
    do_reset();
    vld_in = 1'b1; addr_in = 64'h900; cycle();
    for (int k = 1; k <= CMAX + 3; k++) begin
      addr_in = 64'h900 + 64'($urandom_range(0, LW - 1));
      cycle();
      total++; if (coal !== CW'((k < CMAX) ? k : CMAX)) begin
        $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, coal, (k < CMAX) ? k : CMAX); bad++; end
    end
    vld_in = 1'b0;
    total++; if (pending !== 3'd1) begin $display("FAIL sat_pending got=%0d exp=1", pending); bad++; end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      vld_in  = ($urandom_range(0, 3) != 0);
      rdy_in  = ($urandom_range(0, 2) == 0);
      en      = ($urandom_range(0, 9) != 0);
      addr_in = 64'h8000_0000 + 64'(16 * $urandom_range(0, 7)) + 64'($urandom_range(0, 15));
      total++; if (vld_out !== (mq.size() > 0)) begin
        $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", n, vld_out, mq.size() > 0); bad++; end
      if (mq.size() > 0) begin
        total++; if (addr_out !== mq[0]) begin
          $display("FAIL rnd_addr[%0d] got=%h exp=%h", n, addr_out, mq[0]); bad++; end
      end
      total++; if (pending !== 3'(mq.size())) begin
        $display("FAIL rnd_pending[%0d] got=%0d exp=%0d", n, pending, mq.size()); bad++; end
      total++; if (rdy_out !== (mq.size() != DEPTH)) begin
        $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, rdy_out, mq.size() != DEPTH); bad++; end
      total++; if (empty !== (mq.size() == 0)) begin
        $display("FAIL rnd_empty[%0d] got=%0b exp=%0b", n, empty, mq.size() == 0); bad++; end
      total++; if (coal !== CW'(mcoal)) begin
        $display("FAIL rnd_coal[%0d] got=%0d exp=%0d", n, coal, mcoal); bad++; end
      cycle();
    end
    vld_in = 1'b0;
    en     = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    addr_in = '0;
    mcoal   = 0;
    #12;
    test_reset();
    test_single();
    test_coalesce();
    test_full();
    test_head_pop();
    test_disable();
    test_async_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
